// File: rtl/bitwise_issue_queue.sv
// Operand FIFO feeding a registered bitwise gate stage with valid/ready on both sides.
// Define BITWISE_ISSUE_PARITY_EN to add the registered parity flag on each result.
module bitwise_issue_queue #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       out_op,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_parity,
   output logic [7:0]       issue_cnt
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [2:0]       op_mem_q [DEPTH];
   logic [WIDTH-1:0] a_mem_q  [DEPTH];
   logic [WIDTH-1:0] b_mem_q  [DEPTH];

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             out_valid_q, out_valid_d;
   logic [2:0]       out_op_q;
   logic [WIDTH-1:0] out_result_q;
   logic             out_zero_q;
   logic [7:0]       issue_cnt_q, issue_cnt_d;

   logic             full, empty, push, pop, handoff;
   logic [2:0]       head_op;
   logic [WIDTH-1:0] head_res;

   function automatic logic [WIDTH-1:0] gate_eval(input logic [2:0]       op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      case (op)
         3'b000:  r = a & b;
         3'b001:  r = a | b;
         3'b010:  r = a ^ b;
         3'b011:  r = ~(a ^ b);
         3'b100:  r = ~(a & b);
         3'b101:  r = ~(a | b);
         3'b110:  r = ~a;
         default: r = a;
      endcase
      return r;
   endfunction

   // A full queue refuses input even when it pops, so in_ready depends only on state.
   always_comb begin
      full     = (count_q == FULL_CNT);
      empty    = (count_q == '0);
      push     = in_valid && !full;
      handoff  = out_valid_q && out_ready;
      pop      = !empty && (!out_valid_q || out_ready);
      head_op  = op_mem_q[rd_ptr_q];
      head_res = gate_eval(head_op, a_mem_q[rd_ptr_q], b_mem_q[rd_ptr_q]);

      wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d     = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      out_valid_d = out_valid_q;
      if (pop)
         out_valid_d = 1'b1;
      else if (handoff)
         out_valid_d = 1'b0;
      issue_cnt_d = issue_cnt_q + 8'(handoff);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         op_mem_q[wr_ptr_q] <= in_op;
         a_mem_q[wr_ptr_q]  <= in_a;
         b_mem_q[wr_ptr_q]  <= in_b;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         out_valid_q  <= 1'b0;
         out_op_q     <= '0;
         out_result_q <= '0;
         out_zero_q   <= 1'b0;
         issue_cnt_q  <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         issue_cnt_q <= issue_cnt_d;
         if (pop) begin
            out_op_q     <= head_op;
            out_result_q <= head_res;
            out_zero_q   <= (head_res == '0);
         end
      end
   end

`ifdef BITWISE_ISSUE_PARITY_EN
   logic out_parity_q;

   always_ff @(posedge clk) begin
      if (rst)
         out_parity_q <= 1'b0;
      else if (pop)
         out_parity_q <= ^head_res;
   end

   assign out_parity = out_parity_q;
`else
   assign out_parity = 1'b0;
`endif

   assign in_ready   = !full;
   assign out_valid  = out_valid_q;
   assign out_op     = out_op_q;
   assign out_result = out_result_q;
   assign out_zero   = out_zero_q;
   assign issue_cnt  = issue_cnt_q;

endmodule
